// File: rtl/bcd_scan_controller.sv
// Basys 3 seven-segment controller: iterative double-dabble binary-to-BCD conversion,
// atomic commit to display registers, and refresh-counter driven anode multiplexing.
module bcd_scan_controller #(
    parameter int BIN_WIDTH    = 14,
    parameter int REFRESH_BITS = 20
) (
    input  logic                 clock_100Mhz,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 blank_lz,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           Anode_Activate,
    output logic [6:0]           LED_out
);

    localparam int SR_W  = 16 + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);
    localparam logic [BIN_WIDTH-1:0] MAX_DEC   = BIN_WIDTH'(9999);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SR_W-1:0]         sr_q, sr_d, sr_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_cap_q, ovf_cap_d;
    logic [15:0]             digits_q, digits_d;
    logic                    ovf_disp_q, ovf_disp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_cap_d  = ovf_cap_q;
        digits_d   = digits_q;
        ovf_disp_d = ovf_disp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        refresh_d  = refresh_q + 1'b1;

        // Add-3 correction on every BCD nibble before the shift of each iteration.
        sr_adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[BIN_WIDTH + 4*i +: 4] >= 4'd5)
                sr_adj[BIN_WIDTH + 4*i +: 4] = sr_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d      = {16'b0, bin_in};
                    cnt_d     = '0;
                    ovf_cap_d = (bin_in > MAX_DEC);
                    busy_d    = 1'b1;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                digits_d   = sr_q[SR_W-1:BIN_WIDTH];
                ovf_disp_d = ovf_cap_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_cap_q  <= 1'b0;
            digits_q   <= '0;
            ovf_disp_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            refresh_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_cap_q  <= ovf_cap_d;
            digits_q   <= digits_d;
            ovf_disp_q <= ovf_disp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            refresh_q  <= refresh_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [1:0] sel;
    logic [3:0] nib;
    logic       lz3, lz2, lz1, blank_cur;

    // Anode and cathode share the same sel, so they always switch together.
    always_comb begin
        sel = refresh_q[REFRESH_BITS-1 -: 2];
        lz3 = (digits_q[15:12] == 4'd0);
        lz2 = lz3 && (digits_q[11:8] == 4'd0);
        lz1 = lz2 && (digits_q[7:4] == 4'd0);
        Anode_Activate = 4'b1110;
        nib            = digits_q[3:0];
        blank_cur      = 1'b0;
        case (sel)
            2'd0: begin Anode_Activate = 4'b1110; nib = digits_q[3:0];   blank_cur = 1'b0; end
            2'd1: begin Anode_Activate = 4'b1101; nib = digits_q[7:4];   blank_cur = lz1;  end
            2'd2: begin Anode_Activate = 4'b1011; nib = digits_q[11:8];  blank_cur = lz2;  end
            default: begin Anode_Activate = 4'b0111; nib = digits_q[15:12]; blank_cur = lz3; end
        endcase
        if (ovf_disp_q)
            LED_out = 7'b1111110;
        else if (blank_lz && blank_cur)
            LED_out = 7'b1111111;
        else
            LED_out = seg7(nib);
    end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench for bcd_scan_controller: stimulus pushes expected digit patterns,
// a negedge monitor pops and checks them on every done pulse.
module tb_bcd_scan_controller;
  localparam int BW = 14;
  localparam int RB = 6;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111, SD = 7'b1111110;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          blank_lz = 1'b0;
  logic          busy, done;
  logic [3:0]    anode;
  logic [6:0]    led;

  bcd_scan_controller #(.BIN_WIDTH(BW), .REFRESH_BITS(RB)) dut (
    .clock_100Mhz   (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bin_in         (bin_in),
    .blank_lz       (blank_lz),
    .busy           (busy),
    .done           (done),
    .Anode_Activate (anode),
    .LED_out        (led)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [27:0] exp_q[$];   // {d3,d2,d1,d0} cathode patterns

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // monitor / scoreboard
  int          busy_cnt = 0;
  logic [27:0] mon_e;
  logic [6:0]  mon_led;
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          case (anode)
            4'b1110: mon_led = mon_e[6:0];
            4'b1101: mon_led = mon_e[13:7];
            4'b1011: mon_led = mon_e[20:14];
            4'b0111: mon_led = mon_e[27:21];
            default: mon_led = 7'bx;
          endcase
          chk("done_busy_len", busy_cnt, 15);
          chk("done_busy_low", {31'd0, busy}, 32'd0);
          chk("done_led", {25'd0, led}, {25'd0, mon_led});
        end
        busy_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [BW-1:0] v, input logic [27:0] pats);
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(pats);
  endtask

  task automatic wait_done(input string name, input bit release_start);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (release_start && cyc == 1) start = 1'b0;
    end while (!done && cyc < 40);
    chk(name, cyc, 16);
  endtask

  task automatic scan_check(input string name, input logic [27:0] pats);
    logic [3:0] exp_an;
    int n;
    for (int s = 0; s < 4; s++) begin
      exp_an = ~(4'b0001 << s);
      n = 0;
      while (anode !== exp_an && n < 80) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("%s_an%0d", name, s), {28'd0, anode}, {28'd0, exp_an});
      chk($sformatf("%s_d%0d", name, s), {25'd0, led}, {25'd0, pats[7*s +: 7]});
    end
  endtask

  int n_wait;

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("rst_anode", {28'd0, anode}, {28'd0, 4'b1110});
    chk("rst_led",   {25'd0, led},   {25'd0, S0});
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    scan_check("rst_bl0", {S0, S0, S0, S0});
    blank_lz = 1'b1;
    scan_check("rst_bl1", {SB, SB, SB, S0});
    blank_lz = 1'b0;

    launch(14'd1234, {S1, S2, S3, S4});
    wait_done("lat_1234", 1'b1);
    scan_check("v1234", {S1, S2, S3, S4});

    launch(14'd9999, {S9, S9, S9, S9});
    wait_done("lat_9999", 1'b1);
    scan_check("v9999", {S9, S9, S9, S9});

    launch(14'd10000, {SD, SD, SD, SD});
    wait_done("lat_10000", 1'b1);
    scan_check("v10000", {SD, SD, SD, SD});
    blank_lz = 1'b1;
    scan_check("v10000_bl", {SD, SD, SD, SD});

    launch(14'd0, {SB, SB, SB, S0});
    wait_done("lat_0", 1'b1);
    scan_check("v0_bl", {SB, SB, SB, S0});
    launch(14'd7, {SB, SB, SB, S7});
    wait_done("lat_7", 1'b1);
    scan_check("v7_bl", {SB, SB, SB, S7});
    blank_lz = 1'b0;
    scan_check("v7_nobl", {S0, S0, S0, S7});
    blank_lz = 1'b1;
    launch(14'd405, {SB, S4, S0, S5});
    wait_done("lat_405", 1'b1);
    scan_check("v405_bl", {SB, S4, S0, S5});
    blank_lz = 1'b0;

    // starts during a conversion must be dropped, bin_in changes ignored
    launch(14'd500, {S0, S5, S0, S0});
    tick(1);
    start  = 1'b0;
    bin_in = 14'd77;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_wait = 0;
    while (!done && n_wait < 40) begin
      tick(1);
      n_wait++;
    end
    chk("ign_lat", n_wait, 7);
    tick(20);
    scan_check("v500", {S0, S5, S0, S0});

    // start held high: conversions back to back, one every 16 cycles
    launch(14'd16383, {SD, SD, SD, SD});
    exp_q.push_back({SD, SD, SD, SD});
    exp_q.push_back({SD, SD, SD, SD});
    wait_done("held_1", 1'b0);
    wait_done("held_2", 1'b0);
    wait_done("held_3", 1'b0);
    start = 1'b0;
    tick(20);
    chk("held_q_empty", exp_q.size(), 0);

    // reset in the middle of a conversion
    launch(14'd1234, {S1, S2, S3, S4});
    tick(1);
    start = 1'b0;
    tick(6);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_busy",  {31'd0, busy},  32'd0);
    chk("mid_rst_done",  {31'd0, done},  32'd0);
    chk("mid_rst_anode", {28'd0, anode}, {28'd0, 4'b1110});
    chk("mid_rst_led",   {25'd0, led},   {25'd0, S0});
    tick(2);
    reset_n = 1'b1;
    tick(1);
    scan_check("post_rst", {S0, S0, S0, S0});
    launch(14'd42, {S0, S0, S4, S2});
    wait_done("lat_42", 1'b1);
    scan_check("v42", {S0, S0, S4, S2});

    tick(20);
    chk("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
